// File: rtl/pa_fpu_frbus_pkg.sv
// Shared constants for the FPU result-bus writeback buffer: entry layout,
// exception-flag bit positions and default sizing.
package pa_fpu_frbus_pkg;

    localparam int unsigned FRBUS_DATA_W        = 32;
    localparam int unsigned FRBUS_FFLAGS_W      = 5;
    localparam int unsigned FRBUS_DEFAULT_DEPTH = 2;
    localparam int unsigned FRBUS_DEFAULT_DST_W = 5;
    localparam int unsigned FRBUS_ENTRY_W       =
        FRBUS_DATA_W + FRBUS_FFLAGS_W + FRBUS_DEFAULT_DST_W;

    localparam int unsigned FFLAG_NV = 4;
    localparam int unsigned FFLAG_DZ = 3;
    localparam int unsigned FFLAG_OF = 2;
    localparam int unsigned FFLAG_UF = 1;
    localparam int unsigned FFLAG_NX = 0;

    // Entry width for a non-default destination index width.
    function automatic int unsigned frbus_entry_w(input int unsigned dst_w);
        return FRBUS_DATA_W + FRBUS_FFLAGS_W + dst_w;
    endfunction

endpackage

// File: rtl/pa_fpu_frbus_fifo.sv
// In-order flop-array FIFO for writeback entries; one push and one pop per cycle.
module pa_fpu_frbus_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 42
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               push_data_i,
    input  logic                           pop_i,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic [WIDTH-1:0]               head_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Explicit wrap so non-power-of-two depths work.
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/pa_fpu_frbus_wb.sv
// FPU result-bus writeback: arbitrates DP and FDSU results into an in-order buffer
// feeding the register file. Optional sticky fflags accumulator under FPU_FFLAGS_ACC_EN.
module pa_fpu_frbus_wb
    import pa_fpu_frbus_pkg::*;
#(
    parameter int unsigned DEPTH = FRBUS_DEFAULT_DEPTH,
    parameter int unsigned DST_W = FRBUS_DEFAULT_DST_W
) (
    input  logic                      forever_cpuclk,
    input  logic                      cpurst,
    input  logic                      dp_frbus_ex2_vld,
    input  logic [FRBUS_DATA_W-1:0]   dp_frbus_ex2_data,
    input  logic [FRBUS_FFLAGS_W-1:0] dp_frbus_ex2_fflags,
    input  logic [DST_W-1:0]          dp_frbus_ex2_dst,
    input  logic                      fdsu_frbus_vld,
    input  logic [FRBUS_DATA_W-1:0]   fdsu_frbus_data,
    input  logic [FRBUS_FFLAGS_W-1:0] fdsu_frbus_fflags,
    input  logic [DST_W-1:0]          fdsu_frbus_dst,
    output logic                      frbus_fdsu_grant,
    output logic                      frbus_ctrl_ex1_stall,
    input  logic                      rtu_frbus_ready,
    output logic                      frbus_rtu_wb_vld,
    output logic [FRBUS_DATA_W-1:0]   frbus_rtu_wb_data,
    output logic [DST_W-1:0]          frbus_rtu_wb_dst,
    output logic [FRBUS_FFLAGS_W-1:0] frbus_rtu_wb_fflags
`ifdef FPU_FFLAGS_ACC_EN
    ,
    input  logic                      cp0_fpu_fflags_clr,
    output logic [FRBUS_FFLAGS_W-1:0] fpu_cp0_fflags
`endif
);

    localparam int unsigned ENTRY_W = frbus_entry_w(DST_W);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] push_entry;
    logic               full, pop, push_ok, push;

    assign full    = (count == CNT_W'(DEPTH));
    assign pop     = frbus_rtu_wb_vld & rtu_frbus_ready;
    assign push_ok = ~full | pop;

    // DP cannot be held off, so it always wins; FDSU waits for a free slot.
    assign frbus_fdsu_grant = fdsu_frbus_vld & ~dp_frbus_ex2_vld & push_ok;
    assign push             = (dp_frbus_ex2_vld & push_ok) | frbus_fdsu_grant;
    assign push_entry       = dp_frbus_ex2_vld
        ? {dp_frbus_ex2_data, dp_frbus_ex2_fflags, dp_frbus_ex2_dst}
        : {fdsu_frbus_data, fdsu_frbus_fflags, fdsu_frbus_dst};

    // Stalling one entry early leaves room for the result already in EX2.
    assign frbus_ctrl_ex1_stall = (count >= CNT_W'(DEPTH - 1));

    pa_fpu_frbus_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (forever_cpuclk),
        .rst         (cpurst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .count_o     (count),
        .head_o      (head)
    );

    always_comb begin
        frbus_rtu_wb_vld = (count != '0);
        {frbus_rtu_wb_data, frbus_rtu_wb_fflags, frbus_rtu_wb_dst} = '0;
        // Payload is unreset, so only expose it behind a valid entry.
        if (frbus_rtu_wb_vld) begin
            {frbus_rtu_wb_data, frbus_rtu_wb_fflags, frbus_rtu_wb_dst} = head;
        end
    end

`ifdef FPU_FFLAGS_ACC_EN
    logic [FRBUS_FFLAGS_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = cp0_fpu_fflags_clr ? '0 : acc_q;
        if (pop) begin
            acc_d = acc_d | frbus_rtu_wb_fflags;
        end
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign fpu_cp0_fflags = acc_q;
`endif

    dp_overflow_chk: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
        !(dp_frbus_ex2_vld && full && !pop))
        else $error("DP result arrived with writeback buffer full; entry dropped");

endmodule

// File: tb/tb_pa_fpu_frbus_wb.sv
// Scoreboard bench for pa_fpu_frbus_wb: directed scenarios then randomized traffic,
// checked against a queue-based reference model. Build with FPU_FFLAGS_ACC_EN for the accumulator.
module tb_pa_fpu_frbus_wb;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned DST_W = 5;

    typedef struct {
        logic [31:0]      d;
        logic [4:0]       f;
        logic [DST_W-1:0] dst;
    } ent_t;

    logic             clk = 1'b0;
    logic             cpurst;
    logic             dp_vld;
    logic [31:0]      dp_data;
    logic [4:0]       dp_ff;
    logic [DST_W-1:0] dp_dst;
    logic             fdsu_vld;
    logic [31:0]      fdsu_data;
    logic [4:0]       fdsu_ff;
    logic [DST_W-1:0] fdsu_dst;
    logic             grant, stall, ready, wb_vld;
    logic [31:0]      wb_data;
    logic [DST_W-1:0] wb_dst;
    logic [4:0]       wb_ff;
    logic             clr;
    logic [4:0]       acc_out;

    int   n_vec = 0;
    int   n_err = 0;
    ent_t exp_q[$];
    int   occ = 0;
    logic [4:0] acc = '0;
    bit   fdsu_pend = 0;
    ent_t fdsu_ent;

    always #5 clk = ~clk;

    pa_fpu_frbus_wb #(
        .DEPTH (DEPTH),
        .DST_W (DST_W)
    ) dut (
        .forever_cpuclk       (clk),
        .cpurst               (cpurst),
        .dp_frbus_ex2_vld     (dp_vld),
        .dp_frbus_ex2_data    (dp_data),
        .dp_frbus_ex2_fflags  (dp_ff),
        .dp_frbus_ex2_dst     (dp_dst),
        .fdsu_frbus_vld       (fdsu_vld),
        .fdsu_frbus_data      (fdsu_data),
        .fdsu_frbus_fflags    (fdsu_ff),
        .fdsu_frbus_dst       (fdsu_dst),
        .frbus_fdsu_grant     (grant),
        .frbus_ctrl_ex1_stall (stall),
        .rtu_frbus_ready      (ready),
        .frbus_rtu_wb_vld     (wb_vld),
        .frbus_rtu_wb_data    (wb_data),
        .frbus_rtu_wb_dst     (wb_dst),
        .frbus_rtu_wb_fflags  (wb_ff)
`ifdef FPU_FFLAGS_ACC_EN
        ,
        .cp0_fpu_fflags_clr   (clr),
        .fpu_cp0_fflags       (acc_out)
`endif
    );

`ifndef FPU_FFLAGS_ACC_EN
    assign acc_out = '0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic new_fdsu(input logic [31:0] d, input logic [4:0] f, input logic [DST_W-1:0] ds);
        fdsu_ent  = '{d: d, f: f, dst: ds};
        fdsu_pend = 1;
    endtask

    // One cycle: drive at the falling edge, check model against DUT, advance the model.
    task automatic step(input bit dp, input logic [31:0] dd, input logic [4:0] df,
                        input logic [DST_W-1:0] ds, input bit rdy, input bit c);
        bit pop_e, grant_e;
        @(negedge clk);
        dp_vld    = dp;
        dp_data   = dd;
        dp_ff     = df;
        dp_dst    = ds;
        fdsu_vld  = fdsu_pend;
        fdsu_data = fdsu_ent.d;
        fdsu_ff   = fdsu_ent.f;
        fdsu_dst  = fdsu_ent.dst;
        ready     = rdy;
        clr       = c;
        #1;
        pop_e   = (occ != 0) && rdy;
        grant_e = fdsu_pend && !dp && (occ < DEPTH || pop_e);
        check("wb_vld", 64'(wb_vld), 64'(occ != 0));
        check("stall", 64'(stall), 64'(occ >= DEPTH - 1));
        check("grant", 64'(grant), 64'(grant_e));
`ifdef FPU_FFLAGS_ACC_EN
        check("acc", 64'(acc_out), 64'(acc));
        acc = (c ? 5'd0 : acc) | (pop_e ? exp_q[0].f : 5'd0);
`endif
        if (dp) begin
            exp_q.push_back('{d: dd, f: df, dst: ds});
        end else if (grant_e) begin
            exp_q.push_back(fdsu_ent);
            fdsu_pend = 0;
        end
        occ = occ + ((dp || grant_e) ? 1 : 0) - (pop_e ? 1 : 0);
    endtask

    task automatic idle(input bit rdy);
        step(0, '0, '0, '0, rdy, 0);
    endtask

    // Monitor: whenever the DUT retires an entry, compare it with the scoreboard head.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!cpurst && wb_vld && ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("wb_data", 64'(wb_data), 64'(e.d));
                    check("wb_dst", 64'(wb_dst), 64'(e.dst));
                    check("wb_fflags", 64'(wb_ff), 64'(e.f));
                end
            end
        end
    end

    initial begin
        cpurst = 1; dp_vld = 0; dp_data = '0; dp_ff = '0; dp_dst = '0;
        fdsu_vld = 0; fdsu_data = '0; fdsu_ff = '0; fdsu_dst = '0;
        ready = 0; clr = 0;
        fdsu_ent = '{d: '0, f: '0, dst: '0};
        #12;
        check("rst_wb_vld", 64'(wb_vld), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_wb_data", 64'(wb_data), 64'(0));
        check("rst_acc", 64'(acc_out), 64'(0));
        @(negedge clk);
        cpurst = 0;

        // Single DP result, one-cycle latency, then empty.
        step(1, 32'h3F800000, 5'd0, 5'd3, 1, 0);
        idle(1);
        idle(1);

        // DP and FDSU together: DP first, FDSU granted the cycle after.
        new_fdsu(32'h40490FDB, 5'b00001, 5'd7);
        step(1, 32'h11111111, 5'b00010, 5'd1, 1, 0);
        idle(1);
        idle(1);
        idle(1);

        // Fill with ready low, FDSU blocked at full, then full push+pop, then drain.
        step(1, 32'hAAAA0001, 5'b00001, 5'd2, 0, 0);
        new_fdsu(32'hBBBB0002, 5'b10000, 5'd4);
        idle(0);
        new_fdsu(32'hCCCC0003, 5'b00100, 5'd5);
        idle(0);
        step(0, '0, '0, '0, 1, 1);
        for (int i = 0; i < 3; i++) idle(1);

        // Asynchronous reset with two entries buffered.
        step(1, 32'hDEAD0001, 5'd1, 5'd8, 0, 0);
        new_fdsu(32'hDEAD0002, 5'd2, 5'd9);
        idle(0);
        @(negedge clk);
        fdsu_vld = 0;
        #3;
        cpurst = 1;
        #1;
        check("async_rst_wb_vld", 64'(wb_vld), 64'(0));
        check("async_rst_stall", 64'(stall), 64'(0));
        check("async_rst_acc", 64'(acc_out), 64'(0));
        exp_q.delete();
        occ = 0;
        acc = '0;
        @(negedge clk);
        cpurst = 0;

        // Randomized traffic; DP only issued while the upstream stall is low.
        for (int i = 0; i < 600; i++) begin
            bit dp;
            if (!fdsu_pend && $urandom_range(0, 3) == 0) begin
                new_fdsu($urandom, 5'($urandom_range(0, 31)), DST_W'($urandom));
            end
            dp = (occ < DEPTH - 1) && ($urandom_range(0, 2) == 0);
            step(dp, $urandom, 5'($urandom_range(0, 31)), DST_W'($urandom),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        end

        for (int i = 0; i < 20 && (occ != 0 || fdsu_pend); i++) idle(1);
        idle(1);
        check("drained", 64'(exp_q.size()), 64'(0));
        check("fdsu_done", 64'(fdsu_pend), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pa_fpu_frbus_wb.md
PA_FPU_FRBUS_WB -- requirements
Module: pa_fpu_frbus_wb

Interface
REQ-001 SHALL have parameter DEPTH, default 2, writeback buffer entries (legal 2..8).
REQ-002 SHALL have parameter DST_W, default 5, FP destination register index width.
REQ-003 SHALL have port forever_cpuclk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port cpurst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port dp_frbus_ex2_vld  in  1  DP EX2 result valid (ex2_inst_wb qualified by issue); single-cycle, not holdable.
REQ-006 SHALL have ports dp_frbus_ex2_data  in  32, dp_frbus_ex2_fflags  in  5, dp_frbus_ex2_dst  in  DST_W  DP result, exception flags, destination.
REQ-007 SHALL have port fdsu_frbus_vld  in  1  FDSU (div/sqrt) result valid; held until granted.
REQ-008 SHALL have ports fdsu_frbus_data  in  32, fdsu_frbus_fflags  in  5, fdsu_frbus_dst  in  DST_W.
REQ-009 SHALL have port frbus_fdsu_grant  out  1  FDSU result accepted this cycle.
REQ-010 SHALL have port frbus_ctrl_ex1_stall  out  1  upstream EX1 must not advance.
REQ-011 SHALL have port rtu_frbus_ready  in  1  register-file write port accepts.
REQ-012 SHALL have ports frbus_rtu_wb_vld  out  1, frbus_rtu_wb_data  out  32, frbus_rtu_wb_dst  out  DST_W, frbus_rtu_wb_fflags  out  5.
REQ-013 SHALL have ports cp0_fpu_fflags_clr  in  1 and fpu_cp0_fflags  out  5, present only with FPU_FFLAGS_ACC_EN.

Function
REQ-014 SHALL buffer results in an in-order FIFO of DEPTH entries {data, fflags, dst}; at most one push and one pop per cycle.
REQ-015 SHALL push DP when dp_frbus_ex2_vld=1; DP has priority over FDSU.
REQ-016 SHALL assert frbus_fdsu_grant = fdsu_frbus_vld & !dp_frbus_ex2_vld & (count<DEPTH | pop), and push FDSU entry on grant.
REQ-017 SHALL drive frbus_ctrl_ex1_stall = (count >= DEPTH-1), combinationally from registered count, guaranteeing a free entry for any DP EX2 result.
REQ-018 SHALL treat DP valid with count==DEPTH and no pop as protocol error: entry dropped, state unchanged, simulation assertion fires.
REQ-019 SHALL drive frbus_rtu_wb_vld = (count!=0) with head entry on wb_data/dst/fflags; pop = wb_vld & rtu_frbus_ready.
REQ-020 SHALL hold all wb outputs stable while wb_vld=1 and ready=0.
REQ-021 SHALL have latency exactly one cycle: push in cycle N -> wb_vld in N+1 (no bypass), regardless of ready.
REQ-022 SHALL support simultaneous push and pop when full (count unchanged) and when count==1 (new entry becomes head next cycle).
REQ-023 SHALL wrap read/write pointers modulo DEPTH; count width ceil(log2(DEPTH+1)).

Reset
REQ-024 SHALL, on cpurst, asynchronously clear count, pointers and fflags accumulator; wb_vld=0, grant=0, stall=0, fpu_cp0_fflags=0; wb data/dst/fflags outputs 0.
REQ-025 SHALL discard all buffered entries when reset asserts mid-operation; FIFO payload storage need not be reset.

Configuration
REQ-026 SHALL, with FPU_FFLAGS_ACC_EN defined, keep a 5-bit sticky accumulator: next = (clr ? 0 : acc) | (pop ? head_fflags : 0); same-cycle popped flags survive a clear.
REQ-027 SHALL, without FPU_FFLAGS_ACC_EN, omit accumulator and its two ports; flags reported only per entry on frbus_rtu_wb_fflags.

Structure
REQ-028 SHALL place in shared package pa_fpu_frbus_pkg: entry width constant, fflag bit indices (NV=4, DZ=3, OF=2, UF=1, NX=0), default DEPTH.
REQ-029 SHALL implement storage as sub-module pa_fpu_frbus_fifo (push/pop/count, flop array); arbitration, stall and accumulator in the top.

Verification
REQ-030 SHALL cover: DP push data=0x3F800000 dst=3, ready=1 -> wb_vld next cycle with 0x3F800000/dst 3, then wb_vld=0.
REQ-031 SHALL cover: DP and FDSU valid same cycle -> DP pushed, grant=0; FDSU granted next cycle; writeback order DP then FDSU.
REQ-032 SHALL cover: DEPTH=2, ready=0, two pushes -> stall=1 from count=1, FDSU grant=0 at count=2; ready=1 -> entries drain in order, stall drops at count=0.
REQ-033 SHALL cover: full FIFO with ready=1 and FDSU valid -> grant=1, count stays 2, no entry lost.
REQ-034 SHALL cover (FPU_FFLAGS_ACC_EN): pops with fflags 5'b00001 then 5'b10000 -> fpu_cp0_fflags=5'b10001; clr with concurrent pop of 5'b00100 -> 5'b00100.
REQ-035 SHALL cover: cpurst asserted asynchronously with 2 entries buffered -> wb_vld=0 and count=0 before next clock edge.
